hazard_fault_ctrl: RTL and testbench

Pipeline hazard and fault-recovery controller for the five-stage RISC-V core; it drives the stall and clear inputs of the F/D/E/M pipeline registers. It resolves data hazards by forwarding, inserts load-use bubbles, squashes wrong-path instructions on taken branches, and runs a small FSM that flushes the pipe and holds fetch for a fixed recovery window when the memory stage reports a fault. It is the producer side of every pipeline register's flush/stall control.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_fwd_sel.sv | 35 +++
 rtl/hazard_fault_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_fault_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types for the pipeline hazard / fault-recovery
//                controller: ALU operand forwarding selects and the
//                recovery FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // ALU operand source select, matches the E-stage operand mux encoding.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file read value
        FWD_WB  = 2'b01,   // Writeback result
        FWD_MEM = 2'b10    // Memory-stage ALU result
    } fwd_sel_e;

    // Fault-recovery FSM states.
    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_RECOVER = 1'b1
    } hz_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_sel
//  Description : Combinational forwarding selector for one ALU operand.
//                The Memory stage has priority over Writeback because it
//                holds the younger producer. Register x0 is never forwarded.
//  Ports       : RsE_i        - source register of the operand in Execute
//                RdM_i/RdW_i  - destination registers in Memory / Writeback
//                RegWriteM_i  - Memory-stage instruction writes the regfile
//                RegWriteW_i  - Writeback-stage instruction writes the regfile
//                Fwd_o        - selected operand source
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE_i,
    input  logic [4:0] RdM_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    output fwd_sel_e   Fwd_o
);

    always_comb begin
        Fwd_o = FWD_RF;
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == RsE_i)) begin
            Fwd_o = FWD_MEM;
        end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == RsE_i)) begin
            Fwd_o = FWD_WB;
        end
    end

endmodule : hazard_fwd_sel
`default_nettype wire

// File: rtl/hazard_fault_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fault_ctrl
//  Description : Hazard and fault-recovery controller for the five-stage
//                core. Produces operand forwarding selects, load-use stalls,
//                branch squashes, and a RUN/RECOVER FSM that flushes the
//                pipe and holds fetch for RECOVER_CYCLES cycles after an
//                accepted Memory-stage fault.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                Rs1D/Rs2D                  - Decode source registers
//                Rs1E/Rs2E/RdE              - Execute source/dest registers
//                RdM/RdW, RegWriteM/W       - producers in Memory/Writeback
//                ResultSrcE0                - Execute instruction is a load
//                PCSrcE                     - taken branch/jump in Execute
//                FaultM                     - Memory-stage fault
//                ForwardAE/BE               - ALU operand source selects
//                StallF/StallD              - hold PC and F/D register
//                FlushD/FlushE/FlushM       - clear D/E/M pipeline registers
//                TrapRedirectF              - PC mux selects trap vector
//                RecoverBusy                - FSM is in RECOVER
//                FaultCount                 - saturating accepted-fault count
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fault_ctrl
    import hazard_pkg::*;
#(
    parameter int RECOVER_CYCLES = 2,   // legal range 1..255
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             FaultM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             TrapRedirectF,
    output logic             RecoverBusy,
    output logic [CNT_W-1:0] FaultCount
);

    localparam int             RC_W      = $clog2(RECOVER_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LOAD  = RC_W'(RECOVER_CYCLES - 1);

    hz_state_e        state_q, state_d;
    logic [RC_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    fwd_sel_e fwd_a, fwd_b;
    logic     lw_stall;

    // ------------------------------------------------------------------
    // Forwarding, one selector per ALU operand
    // ------------------------------------------------------------------
    hazard_fwd_sel u_fwd_a (
        .RsE_i       (Rs1E),
        .RdM_i       (RdM),
        .RdW_i       (RdW),
        .RegWriteM_i (RegWriteM),
        .RegWriteW_i (RegWriteW),
        .Fwd_o       (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .RsE_i       (Rs2E),
        .RdM_i       (RdM),
        .RdW_i       (RdW),
        .RegWriteM_i (RegWriteM),
        .RegWriteW_i (RegWriteW),
        .Fwd_o       (fwd_b)
    );

    // Load in Execute whose result is needed by the instruction in Decode.
    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and output mux
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fcnt_d        = fcnt_q;
        ForwardAE     = fwd_a;
        ForwardBE     = fwd_b;
        StallF        = 1'b0;
        StallD        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushM        = 1'b0;
        TrapRedirectF = 1'b0;
        RecoverBusy   = 1'b0;

        if (reset) begin
            // Clear every pipeline register while reset is held.
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            state_d   = HZ_RUN;
            cnt_d     = '0;
            fcnt_d    = '0;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (FaultM) begin
                        // Kill everything younger than and including the
                        // faulting instruction, redirect fetch to the trap.
                        FlushD        = 1'b1;
                        FlushE        = 1'b1;
                        FlushM        = 1'b1;
                        TrapRedirectF = 1'b1;
                        state_d       = HZ_RECOVER;
                        cnt_d         = RC_LOAD;
                        if (!(&fcnt_q)) begin
                            fcnt_d = fcnt_q + CNT_W'(1);
                        end
                    end else begin
                        StallF = lw_stall;
                        StallD = lw_stall;
                        FlushD = PCSrcE;
                        FlushE = lw_stall | PCSrcE;
                    end
                end
                HZ_RECOVER: begin
                    // Trap-vector instruction waits in F; bubbles downstream.
                    StallF      = 1'b1;
                    FlushD      = 1'b1;
                    FlushE      = 1'b1;
                    RecoverBusy = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = HZ_RUN;
                    end else begin
                        cnt_d = cnt_q - RC_W'(1);
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign FaultCount = fcnt_q;

endmodule : hazard_fault_ctrl
`default_nettype wire

// File: tb/tb_hazard_fault_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_fault_ctrl
//  Description : Directed self-checking bench for hazard_fault_ctrl with
//                RECOVER_CYCLES=2, CNT_W=8. Control outputs are compared as
//                a packed vector {StallF,StallD,FlushD,FlushE,FlushM,
//                TrapRedirectF,RecoverBusy}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fault_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, FaultM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE, FlushM;
    logic       TrapRedirectF, RecoverBusy;
    logic [7:0] FaultCount;

    int n_cmp = 0;
    int n_err = 0;

    // Control vector bit order: S_F S_D F_D F_E F_M TRAP BUSY
    localparam logic [6:0] C_IDLE    = 7'b0000000;
    localparam logic [6:0] C_RESET   = 7'b0011100;
    localparam logic [6:0] C_LOADUSE = 7'b1101000;
    localparam logic [6:0] C_BR      = 7'b0011000;
    localparam logic [6:0] C_BR_LU   = 7'b1111000;
    localparam logic [6:0] C_FAULT   = 7'b0011110;
    localparam logic [6:0] C_RECOVER = 7'b1011001;

    wire [6:0] ctl = {StallF, StallD, FlushD, FlushE, FlushM,
                      TrapRedirectF, RecoverBusy};

    hazard_fault_ctrl #(
        .RECOVER_CYCLES (2),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Rs1D          (Rs1D),
        .Rs2D          (Rs2D),
        .Rs1E          (Rs1E),
        .Rs2E          (Rs2E),
        .RdE           (RdE),
        .RdM           (RdM),
        .RdW           (RdW),
        .RegWriteM     (RegWriteM),
        .RegWriteW     (RegWriteW),
        .ResultSrcE0   (ResultSrcE0),
        .PCSrcE        (PCSrcE),
        .FaultM        (FaultM),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .FlushM        (FlushM),
        .TrapRedirectF (TrapRedirectF),
        .RecoverBusy   (RecoverBusy),
        .FaultCount    (FaultCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0;  RdM = 5'd0;  RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; FaultM = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        // Reset cycle: matching forward inputs must still give 00.
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        #1;
        chk("reset_ctl", 32'(ctl), 32'(C_RESET));
        chk("reset_fwdA", 32'(ForwardAE), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("post_reset_ctl", 32'(ctl), 32'(C_IDLE));
        chk("post_reset_cnt", 32'(FaultCount), 32'd0);

        // ---------------- Forwarding ----------------
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        #1 chk("fwdA_mem_prio", 32'(ForwardAE), 32'd2);
        RdM = 5'd0;
        #1 chk("fwdA_wb", 32'(ForwardAE), 32'd1);
        RegWriteW = 1'b0;
        #1 chk("fwdA_rf", 32'(ForwardAE), 32'd0);
        idle();
        Rs2E = 5'd9; RdW = 5'd9; RegWriteW = 1'b1; RdM = 5'd9; RegWriteM = 1'b0;
        #1 chk("fwdB_wb_mem_nowrite", 32'(ForwardBE), 32'd1);
        RdW = 5'd0; Rs2E = 5'd0;
        #1 chk("fwdB_x0", 32'(ForwardBE), 32'd0);
        tick();

        // ---------------- Load-use ----------------
        idle();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1 chk("loaduse_ctl", 32'(ctl), 32'(C_LOADUSE));
        tick();
        // Bubble has moved into E: no load in E any more.
        ResultSrcE0 = 1'b0;
        #1 chk("loaduse_one_cycle", 32'(ctl), 32'(C_IDLE));
        ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1 chk("loaduse_rd0", 32'(ctl), 32'(C_IDLE));
        tick();

        // ---------------- Branch ----------------
        idle();
        PCSrcE = 1'b1;
        #1 chk("branch_only", 32'(ctl), 32'(C_BR));
        ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
        #1 chk("branch_and_loaduse", 32'(ctl), 32'(C_BR_LU));
        tick();

        // ---------------- Fault and recovery ----------------
        idle();
        FaultM = 1'b1; PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
        #1 chk("fault_N_ctl", 32'(ctl), 32'(C_FAULT));
        chk("fault_N_cnt", 32'(FaultCount), 32'd0);
        tick();
        idle();
        FaultM = 1'b1;                          // N+1: ignored
        Rs1E = 5'd4; RdW = 5'd4; RegWriteW = 1'b1;
        #1 chk("fault_N1_ctl", 32'(ctl), 32'(C_RECOVER));
        chk("fault_N1_cnt", 32'(FaultCount), 32'd1);
        chk("fault_N1_fwd", 32'(ForwardAE), 32'd1);
        tick();
        idle();
        FaultM = 1'b1;                          // N+2: exit cycle, ignored
        #1 chk("fault_N2_ctl", 32'(ctl), 32'(C_RECOVER));
        tick();
        FaultM = 1'b0;
        #1 chk("fault_N3_run", 32'(ctl), 32'(C_IDLE));
        chk("fault_N3_cnt", 32'(FaultCount), 32'd1);
        FaultM = 1'b1;                          // one cycle after exit: accepted
        #1 chk("fault_after_exit", 32'(ctl), 32'(C_FAULT));
        tick();
        FaultM = 1'b0;
        #1 chk("fault2_cnt", 32'(FaultCount), 32'd2);
        tick();
        tick();
        #1 chk("fault2_back_run", 32'(ctl), 32'(C_IDLE));

        // ---------------- Reset mid-recovery ----------------
        FaultM = 1'b1;
        tick();
        FaultM = 1'b0;
        #1 chk("pre_reset_cnt", 32'(FaultCount), 32'd3);
        reset = 1'b1;
        Rs2E = 5'd6; RdM = 5'd6; RegWriteM = 1'b1;
        #1 chk("midrec_reset_ctl", 32'(ctl), 32'(C_RESET));
        chk("midrec_reset_fwdB", 32'(ForwardBE), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        #1 chk("after_reset_ctl", 32'(ctl), 32'(C_IDLE));
        chk("after_reset_cnt", 32'(FaultCount), 32'd0);

        // ---------------- Saturation ----------------
        for (int i = 1; i <= 300; i++) begin
            FaultM = 1'b1;
            tick();
            FaultM = 1'b0;
            tick();
            tick();
            if (i == 254) chk("sat_254", 32'(FaultCount), 32'd254);
        end
        #1 chk("sat_300", 32'(FaultCount), 32'd255);
        chk("sat_run", 32'(ctl), 32'(C_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_fault_ctrl
`default_nettype wire
